w_74hc153_scan_ctrl: RTL
========================

W_74HC153_SCAN_CTRL -- requirements
Module: w_74hc153_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 2, meaning cycles the select lines are held before the mux output is sampled; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST_N  input  1  reset, asynchronous and active-low.
REQ-004 Start  input  1  request one 4-channel scan; level-sampled each cycle.
REQ-005 Continuous  input  1  when 1, restart the scan automatically after each completed frame.
REQ-006 Result  input  1  output of the downstream 4:1 mux, returned to this block.
REQ-007 Sel0  output  1  mux select bit 0, registered.
REQ-008 Sel1  output  1  mux select bit 1, registered.
REQ-009 Data  output  4  last completed frame; Data[n] = mux channel Dn.
REQ-010 Valid  output  1  one-cycle pulse marking a new frame on Data.
REQ-011 Busy  output  1  high while a scan is in progress.

Function
REQ-012 Channel-to-select mapping: channel n drives Sel0 = n[1] and Sel1 = n[0], so ch0=D0 (00), ch1=D1 (Sel1=1), ch2=D2 (Sel0=1), ch3=D3 (11).
REQ-013 FSM states: IDLE, SETTLE, SAMPLE, DONE; state, channel index ch (2 bits), settle counter (4 bits) and shadow frame register (4 bits) are all registered.
REQ-014 IDLE: Sel1:Sel0 = 00, Busy = 0; Start = 1 moves to SETTLE with ch = 0 and counter = SETTLE-1.
REQ-015 SETTLE: selects drive ch; counter decrements each cycle; counter = 0 moves to SAMPLE.
REQ-016 SAMPLE: one cycle; shadow[ch] <= Result; selects unchanged; ch = 3 moves to DONE, otherwise ch increments, counter reloads SETTLE-1, and the state returns to SETTLE.
REQ-017 DONE: one cycle; Data <= shadow (including the ch3 bit captured in the preceding SAMPLE); Valid = 1; Busy = 0.
REQ-018 From DONE: Continuous = 1 or Start = 1 moves to SETTLE with ch = 0; otherwise the state moves to IDLE.
REQ-019 Busy = 1 in SETTLE and SAMPLE only.
REQ-020 Start asserted while Busy = 1 is ignored and not queued.
REQ-021 Timing: with Start accepted at cycle 0, channel k is sampled at cycle (k+1)(SETTLE+1), and Valid is high at cycle 4(SETTLE+1)+1; for SETTLE = 2, Valid is at cycle 13.
REQ-022 Back-to-back frames in continuous mode: Valid-to-Valid period = 4(SETTLE+1)+1 cycles.
REQ-023 Data holds its value between Valid pulses; a partial frame never reaches Data.
REQ-024 Clearing Continuous mid-scan finishes the current frame, which ends in DONE and then IDLE.
REQ-025 Select outputs change only when entering SETTLE for a new channel, or on entering IDLE (forced to 00).

Reset
REQ-026 RST_N = 0 at any time, including mid-scan, immediately forces state = IDLE, ch = 0, counter = 0, shadow = 0, Data = 4'b0000, Sel0 = Sel1 = 0, Valid = 0, Busy = 0.
REQ-027 After RST_N deasserts, no scan starts until Start = 1 is sampled on a rising edge.

Verification
REQ-028 Bench models the 4:1 mux per REQ-012 with D3..D0 = 1010, SETTLE = 2, single Start pulse -> Sel sequence (Sel1,Sel0) 00,10,01,11 with 3 cycles each; Data = 4'b1010 with Valid at cycle 13; return to IDLE with selects 00.
REQ-029 Continuous = 1 with D3..D0 = 0110, changed to 1001 after the first Valid -> Valid pulses 13 cycles apart; Data = 0110, then 1001; Busy low only in DONE cycles.
REQ-030 Start held high during a scan -> no restart mid-frame; exactly one Valid per 13-cycle frame.
REQ-031 RST_N pulsed low during SETTLE of ch2 -> all outputs 0 immediately; no Valid until a new Start; the next frame is correct.
REQ-032 SETTLE = 1 and SETTLE = 15 builds, D3..D0 = 1111 -> Valid at cycles 9 and 65 respectively; Data = 4'b1111.
REQ-033 Result toggled only during SETTLE cycles -> the captured bit equals the Result value in the SAMPLE cycle.

Source files
------------

// File: rtl/w_74hc153_scan_ctrl.sv
// rtl/w_74hc153_scan_ctrl.sv - scan sequencer for an external 4:1 mux; drives selects and assembles 4-bit frames
// Each channel is held for SETTLE cycles, then sampled once; a full frame is published with a one-cycle valid.
module w_74hc153_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       continuous_i,
  input  logic       result_i,
  output logic       sel0_o,
  output logic       sel1_o,
  output logic [3:0] data_o,
  output logic       valid_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] data_q, data_d;
  logic       sel0_q, sel0_d;
  logic       sel1_q, sel1_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      ch_q     <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 4'd0;
      data_q   <= 4'd0;
      sel0_q   <= 1'b0;
      sel1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      sel0_q   <= sel0_d;
      sel1_q   <= sel1_d;
    end
  end

  // Selects only move when a channel's settle window begins or when the scan goes idle.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    sel0_d   = sel0_q;
    sel1_d   = sel1_q;
    unique case (state_q)
      ST_IDLE: begin
        sel0_d = 1'b0;
        sel1_d = 1'b0;
        if (start_i) begin
          state_d = ST_SETTLE;
          ch_d    = 2'd0;
          cnt_d   = RELOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SAMPLE: begin
        shadow_d[ch_q] = result_i;
        if (ch_q == 2'd3) begin
          // Publish with the last bit folded in so data is visible during the valid cycle.
          state_d = ST_DONE;
          data_d  = {result_i, shadow_q[2:0]};
        end else begin
          state_d = ST_SETTLE;
          ch_d    = 2'(ch_q + 2'd1);
          cnt_d   = RELOAD;
          sel0_d  = ch_d[1];
          sel1_d  = ch_d[0];
        end
      end
      ST_DONE: begin
        ch_d   = 2'd0;
        sel0_d = 1'b0;
        sel1_d = 1'b0;
        if (continuous_i || start_i) begin
          state_d = ST_SETTLE;
          cnt_d   = RELOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    valid_o = (state_q == ST_DONE);
    busy_o  = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    data_o  = data_q;
    sel0_o  = sel0_q;
    sel1_o  = sel1_q;
  end

endmodule
